counter_arb: RTL and testbench

Round-robin scheduler that shares one 8-bit up-counter (count register plus increment logic) among `NREQ` requesters. Each requester asks for a count run of a given length. The block grants the counter to one requester at a time, clears it, enables it for exactly that many cycles, then signals completion. It sits between the requesting control logic and the counter's enable/clear inputs and observes the counter's registered value.

---
 rtl/counter_arb.sv | 111 +++++++++++
 tb/tb_counter_arb.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_arb.sv
// counter_arb: round-robin scheduler that shares one up-counter
// among NREQ requesters, each asking for a run of a given length.
module counter_arb #(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] len,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic              cnt_en,
  output logic              cnt_clr,
  input  logic [W-1:0]      cnt_val
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  state_t          state;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   last;
  logic [IW-1:0]   win;
  logic [W-1:0]    tgt;
  logic            found;
  logic            live;
  logic            hit;
  int              j;

  // Search starts just after the last served requester and wraps.
  always_comb begin
    win   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(last) + k) % NREQ;
      if (!found && req[j]) begin
        found = 1'b1;
        win   = j[IW-1:0];
      end
    end
  end

  assign live    = req[idx];
  assign hit     = (cnt_val == tgt);
  assign busy    = (state != S_IDLE);
  assign cnt_clr = (state == S_CLEAR);
  assign cnt_en  = (state == S_RUN) && live && !hit;
  assign done    = (state == S_DONE) ? (ONE << idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      gnt   <= '0;
      tgt   <= '0;
      idx   <= '0;
      last  <= IW'(NREQ - 1);
    end else begin
      unique case (state)
        S_IDLE: begin
          if (found) begin
            tgt   <= len[win*W +: W];
            idx   <= win;
            gnt   <= ONE << win;
            state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (!live) begin
            state <= S_IDLE;
            gnt   <= '0;
            last  <= idx;
          end else if (tgt != '0) begin
            state <= S_RUN;
          end else begin
            state <= S_DONE;
          end
        end
        S_RUN: begin
          if (!live) begin
            state <= S_IDLE;
            gnt   <= '0;
            last  <= idx;
          end else if (hit) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          gnt   <= '0;
          last  <= idx;
        end
        default: begin
          state <= S_IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_arb.sv
// tb_counter_arb: directed tests for counter_arb with a
// behavioural model of the shared counter.
module tb_counter_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] len;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic        cnt_en;
  logic        cnt_clr;
  logic [7:0]  cnt_val;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  counter_arb #(.NREQ(4), .W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .len(len),
    .gnt(gnt), .done(done), .busy(busy),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr), .cnt_val(cnt_val)
  );

  always @(posedge clk) begin
    if (rst || cnt_clr) cnt_val <= 8'd0;
    else if (cnt_en)    cnt_val <= cnt_val + 8'd1;
  end

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; len = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({gnt, done, busy, cnt_en, cnt_clr} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_outs: got %b want 0",
               {gnt, done, busy, cnt_en, cnt_clr});
    end
    n_cmp++;
    if (cnt_val !== 8'd0) begin
      n_err++;
      $display("FAIL reset_cnt: got %0d want 0", cnt_val);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int ens = 0;
    int stray = 0;
    req = 4'b0001; len[7:0] = 8'd5;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (cnt_en) ens++;
      if (c == 1) begin
        n_cmp++;
        if (gnt !== 4'b0001) begin
          n_err++;
          $display("FAIL single_gnt: got %b want 0001", gnt);
        end
      end
      if (c == 7) begin
        n_cmp++;
        if (cnt_val !== 8'd5 || cnt_en !== 1'b0) begin
          n_err++;
          $display("FAIL single_end: got val=%0d en=%b want 5/0",
                   cnt_val, cnt_en);
        end
      end
      if (c == 8) begin
        n_cmp++;
        if (done !== 4'b0001) begin
          n_err++;
          $display("FAIL single_done: got %b want 0001", done);
        end
        req = 4'b0000;
      end else if (done !== 4'b0000) begin
        stray++;
      end
      if (c == 9) begin
        n_cmp++;
        if (busy !== 1'b0) begin
          n_err++;
          $display("FAIL single_busy: got %b want 0", busy);
        end
      end
    end
    n_cmp++;
    if (ens != 5 || stray != 0) begin
      n_err++;
      $display("FAIL single_en: got en=%0d stray=%0d want 5/0",
               ens, stray);
    end
  endtask

  task automatic test_round_robin();
    int nd = 0;
    int bad = 0;
    logic [3:0] exp;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1111;
    len = {4{8'd2}};
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if ((gnt & (gnt - 4'd1)) != 4'd0) bad++;
      if (done !== 4'b0000) begin
        exp = 4'b0001 << (nd % 4);
        n_cmp++;
        if (done !== exp || c != 5 + 6 * nd) begin
          n_err++;
          $display("FAIL rr_done%0d: got %b@%0d want %b@%0d",
                   nd, done, c, exp, 5 + 6 * nd);
        end
        nd++;
        if (nd == 5) req = 4'b0000;
      end
    end
    n_cmp++;
    if (nd != 5 || bad != 0) begin
      n_err++;
      $display("FAIL rr_count: got done=%0d bad=%0d want 5/0",
               nd, bad);
    end
  endtask

  task automatic test_zero_len();
    int ens = 0;
    int dc = 0;
    req = 4'b0001; len = '0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (cnt_en) ens++;
      if (done !== 4'b0000) begin
        dc = c;
        req = 4'b0000;
      end
    end
    n_cmp++;
    if (ens != 0 || dc != 2) begin
      n_err++;
      $display("FAIL zero_len: got en=%0d done@%0d want 0/2",
               ens, dc);
    end
  endtask

  task automatic test_max_len();
    int ens = 0;
    int dc = 0;
    req = 4'b0010; len[15:8] = 8'd255;
    for (int c = 1; c <= 260; c++) begin
      @(negedge clk);
      if (cnt_en) ens++;
      if (c == 257) begin
        n_cmp++;
        if (cnt_val !== 8'd255 || cnt_en !== 1'b0) begin
          n_err++;
          $display("FAIL max_end: got val=%0d en=%b want 255/0",
                   cnt_val, cnt_en);
        end
      end
      if (done !== 4'b0000) begin
        dc = c;
        req = 4'b0000;
      end
    end
    n_cmp++;
    if (ens != 255 || dc != 258 || cnt_val !== 8'd255) begin
      n_err++;
      $display("FAIL max_run: got en=%0d done@%0d val=%0d want 255/258/255",
               ens, dc, cnt_val);
    end
  endtask

  task automatic test_abort();
    int stray = 0;
    req = 4'b0100; len[23:16] = 8'd10;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (done !== 4'b0000) stray++;
    end
    n_cmp++;
    if (cnt_en !== 1'b1 || cnt_val !== 8'd3) begin
      n_err++;
      $display("FAIL abort_pre: got en=%b val=%0d want 1/3",
               cnt_en, cnt_val);
    end
    req = 4'b0000;
    #1;
    n_cmp++;
    if (cnt_en !== 1'b0) begin
      n_err++;
      $display("FAIL abort_en: got %b want 0", cnt_en);
    end
    @(negedge clk);
    if (done !== 4'b0000) stray++;
    n_cmp++;
    if (busy !== 1'b0 || gnt !== 4'b0000 || stray != 0) begin
      n_err++;
      $display("FAIL abort_idle: got busy=%b gnt=%b stray=%0d want 0/0000/0",
               busy, gnt, stray);
    end
    req = 4'b1001; len = '0;
    @(negedge clk);
    n_cmp++;
    if (gnt !== 4'b1000) begin
      n_err++;
      $display("FAIL abort_next: got %b want 1000", gnt);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 4'b1000) begin
      n_err++;
      $display("FAIL abort_done3: got %b want 1000", done);
    end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    req = 4'b0001; len[7:0] = 8'd20;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (cnt_en !== 1'b1) begin
      n_err++;
      $display("FAIL mid_run: got en=%b want 1", cnt_en);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({gnt, done, busy, cnt_en, cnt_clr} !== 11'd0 ||
        cnt_val !== 8'd0) begin
      n_err++;
      $display("FAIL mid_reset: got %b val=%0d want 0/0",
               {gnt, done, busy, cnt_en, cnt_clr}, cnt_val);
    end
    rst = 1'b0;
    req = 4'b0011;
    @(negedge clk);
    n_cmp++;
    if (gnt !== 4'b0001) begin
      n_err++;
      $display("FAIL mid_regrant: got %b want 0001", gnt);
    end
    req = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_len_sample();
    int ens = 0;
    int dc = 0;
    req = 4'b0010; len[15:8] = 8'd3;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) len[15:8] = 8'd9;
      if (cnt_en) ens++;
      if (done !== 4'b0000) begin
        dc = c;
        req = 4'b0000;
      end
    end
    n_cmp++;
    if (ens != 3 || dc != 6) begin
      n_err++;
      $display("FAIL len_sample: got en=%0d done@%0d want 3/6",
               ens, dc);
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; len = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_zero_len();
    test_max_len();
    test_abort();
    test_reset_mid();
    test_len_sample();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
